ps2_rx_fifo_interface: RTL and testbench

Next-generation PS/2 keyboard/mouse receive port for the system bus. It deserialises device-to-host frames, checks start, parity and stop bits, and queues good bytes in a parametrised FIFO so bursts (multi-byte scancodes, mouse packets) survive slow CPU polling. It adds an interrupt, sticky error flags with write-1-to-clear, and a mid-frame timeout. It sits on the same chip-select style peripheral bus as the other I/O blocks.

---
 rtl/ps2_rx_fifo_interface_pkg.sv | 27 ++
 rtl/ps2_rx_fifo_interface_if.sv | 21 ++
 rtl/ps2_rx_frame.sv | 129 ++++++++++++
 rtl/ps2_rx_fifo_interface.sv | 106 ++++++++++
 tb/tb_ps2_rx_fifo_interface.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/ps2_rx_fifo_interface_pkg.sv
// Shared definitions for the PS/2 receive port: status word layout, frame FSM states,
// frame length and the parity helper.
package ps2_rx_fifo_interface_pkg;

  localparam int unsigned StatusNotEmptyBit = 31;
  localparam int unsigned StatusParityBit   = 30;
  localparam int unsigned StatusOverflowBit = 29;
  localparam int unsigned StatusFramingBit  = 28;
  localparam int unsigned CountMsb          = 23;
  localparam int unsigned CountLsb          = 16;

  // Start + 8 data + parity + stop.
  localparam int unsigned FrameBits = 11;
  localparam int unsigned DataBits  = FrameBits - 3;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StParity,
    StStop
  } frame_state_e;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_interface_if.sv
// Chip-select style peripheral bus seen by the PS/2 receive port.
interface ps2_rx_fifo_interface_if;
  logic        read;
  logic        write;
  logic        status_cs;
  logic        scancode_cs;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        data_out_valid;
  logic        irq;

  modport master (
    output read, write, status_cs, scancode_cs, data_in,
    input  data_out, data_out_valid, irq
  );

  modport slave (
    input  read, write, status_cs, scancode_cs, data_in,
    output data_out, data_out_valid, irq
  );
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: synchroniser, clock glitch filter, falling-edge sample
// pulse, frame FSM with mid-frame timeout and parity/stop checking.
module ps2_rx_frame
  import ps2_rx_fifo_interface_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       push_o,
  output logic       parity_fail_o,
  output logic       framing_fail_o
);

  localparam int unsigned FiltW = $clog2(FILTER_CYCLES + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_s, data_s;
  logic                   filt_q, filt_d;
  logic [FiltW-1:0]       filt_cnt_q, filt_cnt_d;
  logic                   sample_q, sample_data_q;

  frame_state_e           state_q;
  logic [7:0]             shift_q;
  logic [2:0]             bit_cnt_q;
  logic                   parity_q;
  logic [TmoW-1:0]        tmo_q;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];

  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_s != filt_q) begin
      if (filt_cnt_q == FiltW'(FILTER_CYCLES - 1)) begin
        filt_d = clk_s;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  // Idle bus level is high, so the input path resets to 1 to avoid a spurious fall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q    <= '1;
      data_sync_q   <= '1;
      filt_q        <= 1'b1;
      filt_cnt_q    <= '0;
      sample_q      <= 1'b0;
      sample_data_q <= 1'b1;
    end else begin
      clk_sync_q    <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync_q   <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
      filt_q        <= filt_d;
      filt_cnt_q    <= filt_cnt_d;
      sample_q      <= filt_q & ~filt_d;
      sample_data_q <= data_s;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      parity_q       <= 1'b0;
      tmo_q          <= '0;
      push_o         <= 1'b0;
      parity_fail_o  <= 1'b0;
      framing_fail_o <= 1'b0;
    end else begin
      push_o         <= 1'b0;
      parity_fail_o  <= 1'b0;
      framing_fail_o <= 1'b0;
      if (state_q == StIdle) begin
        tmo_q <= '0;
        if (sample_q) begin
          if (!sample_data_q) begin
            state_q   <= StShift;
            bit_cnt_q <= '0;
          end else begin
            framing_fail_o <= 1'b1;
          end
        end
      end else if (sample_q) begin
        tmo_q <= '0;
        unique case (state_q)
          StShift: begin
            shift_q   <= {sample_data_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'(DataBits - 1)) state_q <= StParity;
          end
          StParity: begin
            parity_q <= sample_data_q;
            state_q  <= StStop;
          end
          StStop: begin
            state_q <= StIdle;
            // A bad stop bit is reported as framing even if parity is also bad.
            if (!sample_data_q) begin
              framing_fail_o <= 1'b1;
            end else if (!odd_parity_ok(shift_q, parity_q)) begin
              parity_fail_o <= 1'b1;
            end else begin
              push_o <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
        state_q        <= StIdle;
        framing_fail_o <= 1'b1;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end
    end
  end

  assign byte_o = shift_q;

endmodule

// File: rtl/ps2_rx_fifo_interface.sv
// PS/2 receive port top: scancode FIFO, sticky W1C error flags, bus register decode and irq.
module ps2_rx_fifo_interface
  import ps2_rx_fifo_interface_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  inout  wire                      ps2_clock,
  inout  wire                      ps2_data,
  ps2_rx_fifo_interface_if.slave   bus
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = AddrW + 1;

  logic [7:0]      rx_byte;
  logic            rx_push, rx_parity_fail, rx_framing_fail;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            parity_err_q, parity_err_d;
  logic            overflow_q, overflow_d;
  logic            framing_err_q, framing_err_d;

  logic            empty, full, pop, push_ok, overflow_set, clr_en;
  logic [31:0]     status_word, scancode_word;
  logic            unused_data_in;

  ps2_rx_frame #(
    .SYNC_STAGES    (SYNC_STAGES),
    .FILTER_CYCLES  (FILTER_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame (
    .clk_i          (clock),
    .rst_ni         (reset_n),
    .ps2_clk_i      (ps2_clock),
    .ps2_data_i     (ps2_data),
    .byte_o         (rx_byte),
    .push_o         (rx_push),
    .parity_fail_o  (rx_parity_fail),
    .framing_fail_o (rx_framing_fail)
  );

  assign empty        = (count_q == '0);
  assign full         = (count_q == CntW'(FIFO_DEPTH));
  assign pop          = bus.read & bus.scancode_cs & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign push_ok      = rx_push & (~full | pop);
  assign overflow_set = rx_push & full & ~pop;
  assign clr_en       = bus.write & bus.status_cs;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop) count_d = count_q + 1'b1;
    else if (pop && !push_ok) count_d = count_q - 1'b1;
    // Set wins over a same-cycle clear.
    parity_err_d  = (parity_err_q  & ~(clr_en & bus.data_in[StatusParityBit]))   | rx_parity_fail;
    overflow_d    = (overflow_q    & ~(clr_en & bus.data_in[StatusOverflowBit])) | overflow_set;
    framing_err_d = (framing_err_q & ~(clr_en & bus.data_in[StatusFramingBit]))  | rx_framing_fail;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      parity_err_q  <= 1'b0;
      overflow_q    <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q       <= count_d;
      parity_err_q  <= parity_err_d;
      overflow_q    <= overflow_d;
      framing_err_q <= framing_err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= rx_byte;
  end

  always_comb begin
    status_word                     = '0;
    status_word[StatusNotEmptyBit]  = ~empty;
    status_word[StatusParityBit]    = parity_err_q;
    status_word[StatusOverflowBit]  = overflow_q;
    status_word[StatusFramingBit]   = framing_err_q;
    status_word[CountMsb:CountLsb]  = 8'(count_q);
    scancode_word                   = empty ? 32'h0 : {mem_q[rd_ptr_q], 24'h0};
    if (bus.status_cs)        bus.data_out = status_word;
    else if (bus.scancode_cs) bus.data_out = scancode_word;
    else                      bus.data_out = 32'h0;
  end

  assign bus.data_out_valid = bus.status_cs | bus.scancode_cs;
  assign bus.irq            = ~empty | parity_err_q | overflow_q | framing_err_q;
  assign unused_data_in     = ^{bus.data_in[31], bus.data_in[27:0]};

endmodule

// File: tb/tb_ps2_rx_fifo_interface.sv
// Directed bench for the PS/2 receive port: valid/bad frames, overflow, full push+pop,
// timeout and mid-frame reset, with hand-computed expected register values.
module tb_ps2_rx_fifo_interface;
  import ps2_rx_fifo_interface_pkg::*;

  localparam int unsigned Depth = 4;
  localparam int unsigned Tmo   = 200;
  localparam int unsigned Half  = 20;

  logic clock;
  logic reset_n;
  logic dev_clk, dev_data;
  wire  ps2_clock_w, ps2_data_w;
  int   n_checks, n_pass;
  logic [31:0] rd, old_val;
  logic        seen;

  assign ps2_clock_w = dev_clk;
  assign ps2_data_w  = dev_data;

  ps2_rx_fifo_interface_if bus_if ();

  ps2_rx_fifo_interface #(
    .FIFO_DEPTH     (Depth),
    .SYNC_STAGES    (2),
    .FILTER_CYCLES  (4),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .ps2_clock (ps2_clock_w),
    .ps2_data  (ps2_data_w),
    .bus       (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic ps2_bit(input logic b);
    dev_data = b;
    repeat (Half) @(negedge clock);
    dev_clk = 1'b0;
    repeat (Half) @(negedge clock);
    dev_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    logic [7:0] v;
    v = b;
    ps2_bit(1'b0);
    for (int i = 0; i < int'(DataBits); i++) ps2_bit(v[i]);
    ps2_bit((~^v) ^ bad_par);
    ps2_bit(1'b1);
    dev_data = 1'b1;
    repeat (Half) @(negedge clock);
  endtask

  task automatic bus_read(input logic status, output logic [31:0] d);
    @(negedge clock);
    bus_if.read        = 1'b1;
    bus_if.status_cs   = status;
    bus_if.scancode_cs = ~status;
    #1 d = bus_if.data_out;
    @(posedge clock);
    #1;
    bus_if.read        = 1'b0;
    bus_if.status_cs   = 1'b0;
    bus_if.scancode_cs = 1'b0;
  endtask

  task automatic bus_write_status(input logic [31:0] v, output logic [31:0] old);
    @(negedge clock);
    bus_if.write     = 1'b1;
    bus_if.status_cs = 1'b1;
    bus_if.data_in   = v;
    #1 old = bus_if.data_out;
    @(posedge clock);
    #1;
    bus_if.write     = 1'b0;
    bus_if.status_cs = 1'b0;
    bus_if.data_in   = 32'h0;
  endtask

  task automatic check_status(input string tag, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(1'b1, d);
    check(tag, d, exp);
  endtask

  task automatic check_pop(input string tag, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(1'b0, d);
    check(tag, d, exp);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    bus_if.read = 1'b0; bus_if.write = 1'b0;
    bus_if.status_cs = 1'b0; bus_if.scancode_cs = 1'b0; bus_if.data_in = 32'h0;
    reset_n = 1'b1;
    #3 reset_n = 1'b0;
    repeat (4) @(negedge clock);
    #1;
    check("rst_irq", {31'b0, bus_if.irq}, 32'h0);
    check("rst_data_out", bus_if.data_out, 32'h0);
    check("rst_valid", {31'b0, bus_if.data_out_valid}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    check_status("rst_status", 32'h0);

    // Valid frame 0x1C.
    send_frame(8'h1C, 1'b0);
    check_status("f1c_status", 32'h8001_0000);
    check("f1c_irq", {31'b0, bus_if.irq}, 32'h1);
    check_pop("f1c_pop", 32'h1C00_0000);
    check_status("f1c_status_empty", 32'h0);
    check("f1c_irq_low", {31'b0, bus_if.irq}, 32'h0);
    check_pop("empty_pop", 32'h0);

    // Bad parity 0x5A, then W1C; the clearing cycle still shows the old flag.
    send_frame(8'h5A, 1'b1);
    check_status("par_status", 32'h4000_0000);
    check("par_irq", {31'b0, bus_if.irq}, 32'h1);
    bus_write_status(32'h4000_0000, old_val);
    check("par_clr_old", old_val, 32'h4000_0000);
    check_status("par_cleared", 32'h0);
    check("par_irq_low", {31'b0, bus_if.irq}, 32'h0);

    // Depth+1 frames without reads: last byte lost.
    for (int i = 0; i <= int'(Depth); i++) send_frame(8'h10 + 8'(i), 1'b0);
    check_status("ovf_status", 32'hA004_0000);
    for (int i = 0; i < int'(Depth); i++) check_pop("ovf_pop", {8'h10 + 8'(i), 24'h0});
    check_status("ovf_drained", 32'h2000_0000);
    bus_write_status(32'h2000_0000, old_val);
    check_status("ovf_cleared", 32'h0);

    // Full FIFO: pop in the same cycle the push arrives.
    for (int i = 0; i < int'(Depth); i++) send_frame(8'h21 + 8'(i), 1'b0);
    check_status("full_status", 32'h8004_0000);
    seen = 1'b0;
    fork
      send_frame(8'h25, 1'b0);
      begin
        for (int i = 0; i < int'(FrameBits * 2 * Half) + 100 && !seen; i++) begin
          @(negedge clock);
          if (dut.u_frame.push_o) begin
            seen = 1'b1;
            bus_if.read = 1'b1;
            bus_if.scancode_cs = 1'b1;
            #1 rd = bus_if.data_out;
            check("simul_pop_data", rd, 32'h2100_0000);
            @(posedge clock);
            #1;
            bus_if.read = 1'b0;
            bus_if.scancode_cs = 1'b0;
          end
        end
      end
    join
    check("simul_push_seen", {31'b0, seen}, 32'h1);
    check_status("simul_status", 32'h8004_0000);
    for (int i = 0; i < int'(Depth); i++) check_pop("simul_drain", {8'h22 + 8'(i), 24'h0});

    // Stall after 5 bits until the timeout fires.
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    dev_data = 1'b1;
    repeat (Tmo + 50) @(negedge clock);
    check_status("tmo_status", 32'h1000_0000);
    check("tmo_idle", 32'(dut.u_frame.state_q), 32'(StIdle));
    bus_write_status(32'h1000_0000, old_val);
    send_frame(8'hF0, 1'b0);
    check_status("tmo_next_status", 32'h8001_0000);
    check_pop("tmo_next_pop", 32'hF000_0000);

    // Reset mid-frame with 3 bytes queued.
    for (int i = 0; i < 3; i++) send_frame(8'h31 + 8'(i), 1'b0);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("mid_rst_irq", {31'b0, bus_if.irq}, 32'h0);
    check("mid_rst_data_out", bus_if.data_out, 32'h0);
    check("mid_rst_valid", {31'b0, bus_if.data_out_valid}, 32'h0);
    check("mid_rst_count", 32'(dut.count_q), 32'h0);
    bus_if.status_cs = 1'b1;
    #1 check("mid_rst_status", bus_if.data_out, 32'h0);
    bus_if.status_cs = 1'b0;
    dev_data = 1'b1;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (2 * Half) @(negedge clock);
    send_frame(8'h12, 1'b0);
    check_status("post_rst_status", 32'h8001_0000);
    check_pop("post_rst_pop", 32'h1200_0000);
    check_status("post_rst_empty", 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
